projectile_motion: RTL and testbench

//  Downstream of the throw stage. Takes the launch pulse, power, wind and thrower, then integrates a ballistic

---
 rtl/projectile_pkg.sv | 13 +
 rtl/projectile_motion_if.sv | 24 ++
 rtl/proj_hit_detect.sv | 42 ++++
 rtl/projectile_motion.sv | 91 +++++++++
 tb/tb_projectile_motion.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/projectile_pkg.sv
// Shared types and constants for the projectile integrator: FSM states,
// signed coordinate type and central-wall geometry.
package projectile_pkg;

  typedef logic signed [12:0] coord_t;

  typedef enum logic [1:0] {IDLE, FLY, DONE} state_t;

  localparam int WALL_X0 = 384;
  localparam int WALL_X1 = 415;
  localparam int WALL_Y  = 416;

endpackage

// File: rtl/projectile_motion_if.sv
// Throw-stage / renderer bundle for the projectile block. The master side
// launches and ticks; the slave side reports position and the verdict.
interface projectile_motion_if;
  logic        frame_tick;
  logic        throw_flag;
  logic [4:0]  power;
  logic [2:0]  wind;
  logic        current_player;
  logic [11:0] proj_x;
  logic [11:0] proj_y;
  logic        proj_active;
  logic        end_throw;
  logic        hit;

  modport master (
    output frame_tick, throw_flag, power, wind, current_player,
    input  proj_x, proj_y, proj_active, end_throw, hit
  );

  modport slave (
    input  frame_tick, throw_flag, power, wind, current_player,
    output proj_x, proj_y, proj_active, end_throw, hit
  );
endinterface

// File: rtl/proj_hit_detect.sv
// Combinational end-of-flight classifier. Central wall test is compiled in
// only with WALL_COLLISION_EN.
module proj_hit_detect
  import projectile_pkg::*;
#(
  parameter int SCREEN_W = 800,
  parameter int GROUND_Y = 536,
  parameter int CAT_X    = 64,
  parameter int DOG_X    = 672,
  parameter int TARGET_W = 64,
  parameter int TARGET_H = 64
) (
  input  coord_t x,
  input  coord_t y,
  input  logic   dir_neg,
  output logic   done,
  output logic   hit,
  output logic   ground
);

  coord_t opp_x;
  logic   in_box, wall, landed, off;

  always_comb begin
    // Only the opponent's box counts; a throw can never strike its own box.
    opp_x  = dir_neg ? coord_t'(CAT_X) : coord_t'(DOG_X);
    in_box = (x >= opp_x) && (x < opp_x + coord_t'(TARGET_W)) &&
             (y >= coord_t'(GROUND_Y - TARGET_H));
`ifdef WALL_COLLISION_EN
    wall   = (x >= coord_t'(WALL_X0)) && (x <= coord_t'(WALL_X1)) &&
             (y >= coord_t'(WALL_Y));
`else
    wall   = 1'b0;
`endif
    landed = y >= coord_t'(GROUND_Y);
    off    = (x < 0) || (x > coord_t'(SCREEN_W - 1));
    hit    = in_box;
    done   = in_box || wall || landed || off;
    ground = !in_box && !wall && landed;
  end

endmodule

// File: rtl/projectile_motion.sv
// Per-frame ballistic integrator with hit/miss verdict for the turn logic.
// Define WALL_COLLISION_EN to add the central wall as an obstacle.
module projectile_motion
  import projectile_pkg::*;
#(
  parameter int SCREEN_W = 800,
  parameter int GROUND_Y = 536,
  parameter int CAT_X    = 64,
  parameter int DOG_X    = 672,
  parameter int TARGET_W = 64,
  parameter int TARGET_H = 64,
  parameter int VY_BASE  = 4,
  parameter int GRAVITY  = 1
) (
  input  logic                clk40MHz,
  input  logic                rst,
  projectile_motion_if.slave  bus
);

  state_t state, state_n;
  coord_t x, y, vx, vy, wind_eff, dx, half_pw;
  logic   dir_neg, upd, verdict;
  logic   done, hit_c, ground;

  proj_hit_detect #(
    .SCREEN_W(SCREEN_W), .GROUND_Y(GROUND_Y), .CAT_X(CAT_X), .DOG_X(DOG_X),
    .TARGET_W(TARGET_W), .TARGET_H(TARGET_H)
  ) u_hit (
    .x(x), .y(y), .dir_neg(dir_neg), .done(done), .hit(hit_c), .ground(ground)
  );

  always_comb begin
    half_pw = coord_t'({9'd0, bus.power[4:1]});
    dx      = (dir_neg ? -vx : vx) + wind_eff;
  end

  always_ff @(posedge clk40MHz or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.throw_flag) state_n = FLY;
      FLY:     if (upd && done) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // upd marks the cycle right after an integration step, when the classifier
  // looks at the freshly updated position.
  always_ff @(posedge clk40MHz or negedge rst) begin
    if (!rst) begin
      x <= '0; y <= '0; vx <= '0; vy <= '0; wind_eff <= '0;
      dir_neg <= 1'b0; upd <= 1'b0; verdict <= 1'b0;
    end else begin
      upd <= 1'b0;
      case (state)
        IDLE: if (bus.throw_flag) begin
          dir_neg  <= bus.current_player;
          wind_eff <= $signed({10'd0, bus.wind}) - 13'sd3;
          x        <= bus.current_player ? coord_t'(DOG_X + TARGET_W / 2)
                                         : coord_t'(CAT_X + TARGET_W / 2);
          y        <= coord_t'(GROUND_Y - TARGET_H);
          vx       <= coord_t'(1) + half_pw;
          vy       <= -(coord_t'(VY_BASE) + half_pw);
          verdict  <= 1'b0;
        end
        FLY: if (upd && done) begin
          verdict <= hit_c;
          if (ground) y <= coord_t'(GROUND_Y);
        end else if (bus.frame_tick) begin
          x   <= x + dx;
          y   <= y + vy;
          vy  <= vy + coord_t'(GRAVITY);
          upd <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.proj_x      = x[12] ? 12'd0 : x[11:0];
  assign bus.proj_y      = y[12] ? 12'd0 : y[11:0];
  assign bus.proj_active = state != IDLE;
  assign bus.end_throw   = state == DONE;
  assign bus.hit         = (state == DONE) && verdict;

endmodule

// File: tb/tb_projectile_motion.sv
// Directed test of projectile_motion: launch, integration, verdicts, latency,
// ignored pulses and mid-flight reset.
module tb_projectile_motion;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0, n_pass = 0, end_cnt = 0, last_hit = 0, e0 = 0;

  always #5 clk = ~clk;

  projectile_motion_if bus();

  projectile_motion dut (.clk40MHz(clk), .rst(rst_n), .bus(bus));

  always @(negedge clk) if (bus.end_throw) begin
    end_cnt  = end_cnt + 1;
    last_hit = bus.hit;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic launch(input bit p, input int pw, input int w, input bit tk);
    @(posedge clk); #1;
    bus.current_player = p;
    bus.power          = 5'(pw);
    bus.wind           = 3'(w);
    bus.throw_flag     = 1'b1;
    bus.frame_tick     = tk;
    @(posedge clk); #1;
    bus.throw_flag = 1'b0;
    bus.frame_tick = 1'b0;
  endtask

  // One frame tick followed by two quiet cycles, so any end pulse is seen.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1 bus.frame_tick = 1'b1;
      @(posedge clk); #1 bus.frame_tick = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_pos(input string tag, input int ex, input int ey);
    chk({tag, "_x"}, bus.proj_x, ex);
    chk({tag, "_y"}, bus.proj_y, ey);
  endtask

  initial begin
    bus.frame_tick = 0; bus.throw_flag = 0; bus.power = 0;
    bus.wind = 0; bus.current_player = 0;
    #12;
    chk("rst_x", bus.proj_x, 0);
    chk("rst_y", bus.proj_y, 0);
    chk("rst_active", bus.proj_active, 0);
    chk("rst_end", bus.end_throw, 0);
    chk("rst_hit", bus.hit, 0);
    rst_n = 1'b1;

    // P0 power 0, calm; a tick coincident with launch must not integrate
    launch(0, 0, 3, 1);
    chk_pos("t1_init", 96, 472);
    chk("t1_active", bus.proj_active, 1);
    tick(1);
    chk_pos("t1_tick1", 97, 468);
    e0 = end_cnt;
    tick(15);
    chk("t1_noend16", end_cnt, e0);
    @(posedge clk); #1 bus.frame_tick = 1'b1;
    @(posedge clk); #1 bus.frame_tick = 1'b0;
    chk("t1_end_lat1", bus.end_throw, 0);
    chk_pos("t1_raw17", 113, 540);
    @(posedge clk); #1;
    chk("t1_end_lat2", bus.end_throw, 1);
    chk("t1_hit", bus.hit, 0);
    chk_pos("t1_clamp", 113, 536);
    @(posedge clk); #1;
    chk("t1_end_off", bus.end_throw, 0);
    chk("t1_inactive", bus.proj_active, 0);
    tick(1);
    chk_pos("t1_hold", 113, 536);

    // P0 full power hits the dog; a second launch pulse mid-flight is ignored
    launch(0, 31, 3, 0);
    e0 = end_cnt;
    tick(5);
    launch(1, 0, 0, 0);
    tick(1);
    chk_pos("t2_tick6", 192, 373);
    tick(12);
    chk_pos("t2_tick18", 384, 283);
    tick(20);
    chk_pos("t2_tick38", 704, 453);
    chk("t2_noend38", end_cnt, e0);
    tick(1);
    chk("t2_end", end_cnt, e0 + 1);
    chk("t2_hit", last_hit, 1);
    chk_pos("t2_tick39", 720, 472);

    // P1 full power hits the cat
    launch(1, 31, 3, 0);
    e0 = end_cnt;
    tick(38);
    chk_pos("t3_tick38", 96, 453);
    chk("t3_noend38", end_cnt, e0);
    tick(1);
    chk("t3_end", end_cnt, e0 + 1);
    chk("t3_hit", last_hit, 1);
    chk_pos("t3_tick39", 80, 472);

    // P0 full power, strong tailwind leaves the screen on the right
    launch(0, 31, 7, 0);
    e0 = end_cnt;
    tick(35);
    chk_pos("t4_tick35", 796, 402);
    chk("t4_noend35", end_cnt, e0);
    tick(1);
    chk("t4_end", end_cnt, e0 + 1);
    chk("t4_hit", last_hit, 0);
    chk("t4_x", bus.proj_x, 816);
    chk("t4_inactive", bus.proj_active, 0);

    // reset mid-flight aborts silently
    launch(0, 0, 3, 0);
    tick(10);
    e0 = end_cnt;
    rst_n = 1'b0;
    #1;
    chk("t5_x", bus.proj_x, 0);
    chk("t5_y", bus.proj_y, 0);
    chk("t5_active", bus.proj_active, 0);
    chk("t5_end", bus.end_throw, 0);
    chk("t5_hit", bus.hit, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);
    chk("t5_noend", end_cnt, e0);
    chk("t5_idle_x", bus.proj_x, 0);
    chk("t5_idle_active", bus.proj_active, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
